rom_mp: RTL and testbench
=========================

ROM_MP -- requirements
Module: rom_mp

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: ROM address width; depth is 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 8: ROM word width.
REQ-003 Parameter NUM_CH, default 2: number of independent read channels, legal range 1..8.
REQ-004 Parameter OUT_REG, default 0: 0 = one-stage read, 1 = extra output pipeline stage.
REQ-005 Parameter INIT_DATA, default all zeros: unpacked array [2**ADDR_WIDTH] of DATA_WIDTH-bit words holding the ROM image.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous and active-low.
REQ-008 REQ_VALID  input  NUM_CH  per-channel read request valid.
REQ-009 REQ_READY  output  NUM_CH  per-channel request accepted this cycle.
REQ-010 REQ_ADDR  input  NUM_CH x ADDR_WIDTH  per-channel read address.
REQ-011 RSP_VALID  output  NUM_CH  per-channel response data valid.
REQ-012 RSP_READY  input  NUM_CH  per-channel consumer ready.
REQ-013 RSP_DATA  output  NUM_CH x DATA_WIDTH  per-channel read data.

Function
REQ-014 Request handshake on channel i: REQ_VALID[i] && REQ_READY[i] at a rising edge; response handshake: RSP_VALID[i] && RSP_READY[i].
REQ-015 Each channel holds a busy flag: set on request handshake, cleared on response handshake; at most one outstanding read per channel.
REQ-016 Eligible channels: REQ_VALID[i] && !busy[i]; a single round-robin arbiter grants at most one eligible channel per cycle.
REQ-017 Round-robin search starts at pointer PTR (reset 0), increasing index with wrap from NUM_CH-1 to 0; after a grant, PTR := granted index + 1 modulo NUM_CH; without a grant PTR holds.
REQ-018 REQ_READY is one-hot or zero, asserted only on the granted channel; depends on REQ_VALID and registered state only, never on RSP_READY.
REQ-019 Read latency: OUT_REG=0 -> RSP_VALID[i] rises the cycle after acceptance; OUT_REG=1 -> two cycles after.
REQ-020 RSP_DATA[i] = INIT_DATA[address accepted on channel i]; it and RSP_VALID[i] hold stable while RSP_READY[i] is low.
REQ-021 After a response handshake, busy clears at that edge; channel i is re-eligible the following cycle (no same-cycle reuse); peak per-channel throughput one read per 2 cycles (OUT_REG=0) or 3 cycles (OUT_REG=1).
REQ-022 With NUM_CH=1, arbitration degenerates to grant = REQ_VALID && !busy; PTR stays 0.
REQ-023 All-channels-requesting case: grants rotate strictly; no channel waits more than NUM_CH-1 grants of others once eligible.
REQ-024 Every address 0..2**ADDR_WIDTH-1 is valid; no error path exists.
REQ-025 ROM contents are fixed at elaboration from INIT_DATA and are never written.

Reset
REQ-026 While rst_n is low at a rising edge: REQ_READY, RSP_VALID, busy flags, pipeline valids all 0, RSP_DATA all 0, PTR 0.
REQ-027 Reset asserted mid-operation discards all in-flight reads and unconsumed responses; no response is produced for them after reset release.
REQ-028 REQ_READY is 0 during reset regardless of REQ_VALID; first grant possible in the first cycle with rst_n high.

Structure
REQ-029 Shared package rom_pkg holds default parameter constants (ADDR_WIDTH, DATA_WIDTH, NUM_CH) and the channel-index width function clog2-based ch_idx_w(NUM_CH).
REQ-030 One sub-module rr_arbiter (parameter N; inputs clk, rst_n, eligible vector; outputs one-hot grant, grant index) contains PTR and the round-robin logic.
REQ-031 A single ROM read port is shared by all channels; the grant-index mux selects REQ_ADDR before the array read.

Verification (ADDR_WIDTH=4, DATA_WIDTH=8, NUM_CH=3, INIT_DATA[k]=8'(3k+1))
REQ-032 Single read: ch0 addr 5, RSP_READY=1, OUT_REG=0 -> RSP_VALID[0] one cycle after accept, RSP_DATA[0]=16; OUT_REG=1 -> two cycles, same data.
REQ-033 Contention: all three REQ_VALID held high, addrs 1,2,3, RSP_READY=1 -> grants ch0,ch1,ch2,ch0... on consecutive cycles; data 4,7,10.
REQ-034 Backpressure: ch1 addr 15, RSP_READY[1]=0 for 5 cycles -> RSP_VALID[1]=1, RSP_DATA[1]=46 stable, REQ_READY[1]=0 throughout; next accept the cycle after RSP_READY[1] rises.
REQ-035 Reset mid-flight: accept ch2 addr 7, assert rst_n=0 next cycle -> all outputs 0; after release no RSP_VALID[2] without a new request.
REQ-036 Wrap/fairness: ch2 granted, then ch0 and ch2 request -> ch0 granted first (PTR wrapped to 0).

Source files
------------

// File: rtl/rom_pkg.sv
// Shared constants and helpers for the multi-port ROM and its arbiter.
package rom_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_CH     = 2;

  // Width of a channel index; never collapses to zero bits for a single channel.
  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rom_mp_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts at the rotating pointer.
module rr_arbiter
  import rom_pkg::*;
#(
  parameter int N = DEF_NUM_CH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           eligible_i,
  output logic [N-1:0]           grant_o,
  output logic [ch_idx_w(N)-1:0] grant_idx_o
);

  localparam int IW = ch_idx_w(N);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cidx;
  logic          found;
  int            c;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    ptr_d       = ptr_q;
    found       = 1'b0;
    c           = 0;
    cidx        = '0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr_q) + k;
      if (c >= N) c = c - N;
      cidx = IW'(c);
      if (!found && eligible_i[cidx]) begin
        found          = 1'b1;
        grant_o[cidx]  = 1'b1;
        grant_idx_o    = cidx;
        // Next search starts just past the winner, wrapping to channel 0.
        ptr_d          = (c == N - 1) ? '0 : IW'(c + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rom_mp.sv
// Multi-channel ROM: channels share one read port through a round-robin arbiter,
// each channel keeps at most one read outstanding.
module rom_mp
  import rom_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter bit OUT_REG    = 1'b0,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA [2**ADDR_WIDTH] = '{default: '0}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            REQ_VALID,
  output logic [NUM_CH-1:0]            REQ_READY,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] REQ_ADDR,
  output logic [NUM_CH-1:0]            RSP_VALID,
  input  logic [NUM_CH-1:0]            RSP_READY,
  output logic [NUM_CH*DATA_WIDTH-1:0] RSP_DATA
);

  localparam int IW = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0]                 eligible, arb_gnt, grant;
  logic [IW-1:0]                     gnt_idx;
  logic [NUM_CH-1:0]                 busy_q, busy_d;
  logic [NUM_CH-1:0]                 rsp_vld_q, rsp_vld_d, rsp_hs;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0]             rd_addr;
  logic [DATA_WIDTH-1:0]             rom_word;

  logic                              dlv_vld;
  logic [IW-1:0]                     dlv_ch;
  logic [DATA_WIDTH-1:0]             dlv_data;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign req_addr[i]                           = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign RSP_DATA[i*DATA_WIDTH +: DATA_WIDTH]  = rsp_data_q[i];
  end

  assign eligible = REQ_VALID & ~busy_q;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .eligible_i  (eligible),
    .grant_o     (arb_gnt),
    .grant_idx_o (gnt_idx)
  );

  // Reset blocks acceptance combinationally so nothing is granted before release.
  assign grant     = rst_n ? arb_gnt : '0;
  assign REQ_READY = grant;

  // Single shared read port: address mux by grant index, then the array lookup.
  assign rd_addr  = req_addr[gnt_idx];
  assign rom_word = INIT_DATA[rd_addr];

  if (OUT_REG) begin : g_oreg
    logic                  pv_q;
    logic [IW-1:0]         pch_q;
    logic [DATA_WIDTH-1:0] pdata_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pv_q    <= 1'b0;
        pch_q   <= '0;
        pdata_q <= '0;
      end else begin
        pv_q    <= |grant;
        pch_q   <= gnt_idx;
        pdata_q <= rom_word;
      end
    end

    assign dlv_vld  = pv_q;
    assign dlv_ch   = pch_q;
    assign dlv_data = pdata_q;
  end else begin : g_noreg
    assign dlv_vld  = |grant;
    assign dlv_ch   = gnt_idx;
    assign dlv_data = rom_word;
  end

  assign rsp_hs = rsp_vld_q & RSP_READY;
  // A channel can only be granted after its previous response drained,
  // so delivery never collides with an unconsumed response.
  assign busy_d = (busy_q | grant) & ~rsp_hs;

  always_comb begin
    rsp_vld_d  = rsp_vld_q;
    rsp_data_d = rsp_data_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rsp_hs[i]) rsp_vld_d[i] = 1'b0;
      if (dlv_vld && dlv_ch == IW'(i)) begin
        rsp_vld_d[i]  = 1'b1;
        rsp_data_d[i] = dlv_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q     <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      busy_q     <= busy_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign RSP_VALID = rsp_vld_q;

endmodule

// File: tb/tb_rom_mp.sv
// Directed bench for rom_mp: two instances, one-stage and registered read.
module tb_rom_mp;

  localparam logic [7:0] IMG [16] = '{8'd1, 8'd4, 8'd7, 8'd10, 8'd13, 8'd16, 8'd19, 8'd22,
                                      8'd25, 8'd28, 8'd31, 8'd34, 8'd37, 8'd40, 8'd43, 8'd46};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  v0, rdy0, rv0, rr0;
  logic [11:0] a0;
  logic [23:0] d0;
  logic [2:0]  v1, rdy1, rv1, rr1;
  logic [11:0] a1;
  logic [23:0] d1;

  int ntot  = 0;
  int npass = 0;

  always #5 clk = ~clk;

  rom_mp #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_CH(3), .OUT_REG(1'b0), .INIT_DATA(IMG)) dut0 (
    .clk(clk), .rst_n(rst_n), .REQ_VALID(v0), .REQ_READY(rdy0), .REQ_ADDR(a0),
    .RSP_VALID(rv0), .RSP_READY(rr0), .RSP_DATA(d0));

  rom_mp #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_CH(3), .OUT_REG(1'b1), .INIT_DATA(IMG)) dut1 (
    .clk(clk), .rst_n(rst_n), .REQ_VALID(v1), .REQ_READY(rdy1), .REQ_ADDR(a1),
    .RSP_VALID(rv1), .RSP_READY(rr1), .RSP_DATA(d1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) begin
      npass++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    v0 = 3'b111; a0 = '0; rr0 = 3'b111;
    v1 = 3'b111; a1 = '0; rr1 = 3'b111;

    // Reset state, with requests pending
    step(); step(); #1;
    chk("rst_ready0", 32'(rdy0), 32'h0);
    chk("rst_rspv0",  32'(rv0),  32'h0);
    chk("rst_data0",  32'(d0),   32'h0);
    chk("rst_ready1", 32'(rdy1), 32'h0);
    chk("rst_rspv1",  32'(rv1),  32'h0);

    // Single read ch0 addr 5 on both latency variants
    step(); rst_n = 1'b1;
    v0 = 3'b001; a0 = {4'd0, 4'd0, 4'd5};
    v1 = 3'b001; a1 = {4'd0, 4'd0, 4'd5}; #1;
    chk("single_ready0", 32'(rdy0), 32'h1);
    chk("single_ready1", 32'(rdy1), 32'h1);
    step(); v0 = '0; v1 = '0; #1;
    chk("single_rspv0",  32'(rv0),     32'h1);
    chk("single_data0",  32'(d0[7:0]), 32'd16);
    chk("oreg_lat1_rspv", 32'(rv1),    32'h0);
    step(); #1;
    chk("single_drain0", 32'(rv0),     32'h0);
    chk("oreg_rspv",     32'(rv1),     32'h1);
    chk("oreg_data",     32'(d1[7:0]), 32'd16);
    step(); #1;
    chk("oreg_drain",    32'(rv1),     32'h0);

    // Fresh reset so the pointer starts at 0, then all three contend
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1; v0 = 3'b111; a0 = {4'd3, 4'd2, 4'd1}; #1;
    chk("cont_g0", 32'(rdy0), 32'h1);
    step(); #1;
    chk("cont_g1",    32'(rdy0), 32'h2);
    chk("cont_rv_c0", 32'(rv0),  32'h1);
    chk("cont_d_c0",  32'(d0[7:0]), 32'd4);
    step(); #1;
    chk("cont_g2",    32'(rdy0), 32'h4);
    chk("cont_rv_c1", 32'(rv0),  32'h2);
    chk("cont_d_c1",  32'(d0[15:8]), 32'd7);
    step(); #1;
    chk("cont_g3_wrap", 32'(rdy0), 32'h1);
    chk("cont_rv_c2",   32'(rv0),  32'h4);
    chk("cont_d_c2",    32'(d0[23:16]), 32'd10);
    v0 = '0;
    step(); #1;
    chk("cont_idle", 32'(rv0), 32'h0);

    // Wrap/fairness: ch2 alone, then ch0 and ch2 both request
    step(); v0 = 3'b100; #1;
    chk("wrap_g_ch2", 32'(rdy0), 32'h4);
    step(); v0 = 3'b000; #1;
    chk("wrap_rv_ch2", 32'(rv0), 32'h4);
    step(); v0 = 3'b101; #1;
    chk("wrap_ch0_first", 32'(rdy0), 32'h1);
    step(); #1;
    chk("wrap_ch2_next", 32'(rdy0), 32'h4);
    chk("wrap_d_ch0",    32'(d0[7:0]), 32'd4);
    v0 = '0;
    step(); #1;
    chk("wrap_d_ch2", 32'(d0[23:16]), 32'd10);

    // Backpressure on ch1, addr 15
    step(); v0 = 3'b010; a0 = {4'd0, 4'd15, 4'd0}; rr0 = 3'b101; #1;
    chk("bp_accept", 32'(rdy0), 32'h2);
    for (int k = 0; k < 5; k++) begin
      step(); #1;
      chk("bp_rspv",  32'(rv0[1]),    32'h1);
      chk("bp_data",  32'(d0[15:8]),  32'd46);
      chk("bp_ready", 32'(rdy0[1]),   32'h0);
    end
    rr0 = 3'b111;
    step(); #1;
    chk("bp_reaccept", 32'(rdy0), 32'h2);
    chk("bp_drained",  32'(rv0),  32'h0);
    v0 = '0;
    step(); #1;
    chk("bp_second_data", 32'(d0[15:8]), 32'd46);

    // Reset mid-flight: ch2 addr 7 accepted, then reset before consumption
    step(); v0 = 3'b100; a0 = {4'd7, 4'd0, 4'd0}; #1;
    chk("mid_accept", 32'(rdy0), 32'h4);
    step(); rst_n = 1'b0; v0 = 3'b111; #1;
    chk("mid_ready_in_rst", 32'(rdy0), 32'h0);
    step(); #1;
    chk("mid_rspv", 32'(rv0), 32'h0);
    chk("mid_data", 32'(d0),  32'h0);
    step(); rst_n = 1'b1; v0 = '0;
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      chk("mid_no_ghost", 32'(rv0), 32'h0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
